// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus rx/tx FIFOs, cycle counter and stop flag behind the CPU memory port.
module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_done,
  output logic        tx_overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [7:0] ram [2**ADDR_WIDTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_rd, rx_wr, tx_rd, tx_wr;
  logic [CW-1:0] rx_cnt, tx_cnt, tx_cnt_nx;
  logic [31:0] cycles, snap;
  logic [15:0] off;
  logic [7:0] io_rd, rd_data;
  logic is_io, rx_push, rx_pop, tx_push, tx_pop, tx_req, tx_full;
  logic unused_addr;

  assign unused_addr = ^mem_addr[31:18];
  assign is_io = mem_addr[17:16] == 2'b11;
  assign off = mem_addr[15:0];
  assign rx_ready = rx_cnt != FULL;
  assign tx_valid = tx_cnt != '0;
  assign tx_full = tx_cnt == FULL;
  assign tx_data = tx_valid ? tx_mem[tx_rd] : 8'h00;
  assign rx_push = rx_valid && rx_ready;
  assign rx_pop = rdy_in && is_io && !mem_wr && off == 16'h0 && rx_cnt != '0;
  assign tx_pop = tx_valid && tx_ready;
  assign tx_req = rdy_in && is_io && mem_wr && off == 16'h0 && mem_dout != 8'h00;
  // a full FIFO still accepts a push when the consumer frees a slot the same edge
  assign tx_push = tx_req && (!tx_full || tx_pop);
  assign tx_cnt_nx = tx_cnt + CW'(tx_push) - CW'(tx_pop);
  assign io_rd = off == 16'h0 ? (rx_cnt != '0 ? rx_mem[rx_rd] : 8'h00) :
                 off == 16'h4 ? cycles[7:0] :
                 off == 16'h5 ? snap[15:8] :
                 off == 16'h6 ? snap[23:16] :
                 off == 16'h7 ? snap[31:24] : 8'h00;
  assign rd_data = is_io ? io_rd : ram[mem_addr[ADDR_WIDTH-1:0]];

  always_ff @(posedge clk_in) begin
    if (rdy_in && mem_wr && !is_io) ram[mem_addr[ADDR_WIDTH-1:0]] <= mem_dout;
    if (rx_push) rx_mem[rx_wr] <= rx_data;
    if (tx_push) tx_mem[tx_wr] <= mem_dout;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din <= 8'h00;
      io_buffer_full <= 1'b0;
      prog_done <= 1'b0;
      tx_overflow <= 1'b0;
      cycles <= '0;
      snap <= '0;
      rx_rd <= '0;
      rx_wr <= '0;
      rx_cnt <= '0;
      tx_rd <= '0;
      tx_wr <= '0;
      tx_cnt <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (rdy_in && !mem_wr) mem_din <= rd_data;
      if (rdy_in && is_io && !mem_wr && off == 16'h4) snap <= cycles;
      if (rdy_in && is_io && mem_wr && off == 16'h4) prog_done <= 1'b1;
      if (tx_req && tx_full && !tx_pop) tx_overflow <= 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop) rx_rd <= rx_rd + 1'b1;
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop) tx_rd <= tx_rd + 1'b1;
      tx_cnt <= tx_cnt_nx;
      io_buffer_full <= tx_cnt_nx == FULL;
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_mem_io_responder;
  localparam int D = 16;

  logic clk_in, rst_in, rdy_in, mem_wr, rx_valid, tx_ready;
  logic [31:0] mem_addr;
  logic [7:0] mem_dout, rx_data, mem_din, tx_data;
  logic io_buffer_full, rx_ready, tx_valid, prog_done, tx_overflow;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .prog_done(prog_done), .tx_overflow(tx_overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_ram [logic [16:0]];
  logic [7:0] m_rx [$];
  logic [7:0] m_tx [$];
  logic [31:0] m_cnt, m_snap;
  logic [7:0] m_din;
  logic m_pd, m_ovf;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  dout;
    logic        wr;
    logic        rxv;
    logic [7:0]  rxd;
    logic [7:0]  exp;
  } vec_t;
  vec_t tv [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [7:0] d, input logic w);
    mem_addr = a;
    mem_dout = d;
    mem_wr = w;
  endtask

  task automatic model_edge();
    logic io, txp, rxp, txpush;
    logic [15:0] o;
    int rxs;
    int txs;
    io = mem_addr[17:16] == 2'b11;
    o = mem_addr[15:0];
    rxs = m_rx.size();
    txs = m_tx.size();
    txp = txs > 0 && tx_ready;
    rxp = rx_valid && rxs < D;
    txpush = 1'b0;
    if (rdy_in) begin
      if (!io) begin
        if (mem_wr) m_ram[mem_addr[16:0]] = mem_dout;
        else m_din = m_ram.exists(mem_addr[16:0]) ? m_ram[mem_addr[16:0]] : 8'hxx;
      end else if (!mem_wr) begin
        if (o == 0) m_din = rxs > 0 ? m_rx.pop_front() : 8'h00;
        else if (o == 4) begin
          m_din = m_cnt[7:0];
          m_snap = m_cnt;
        end else if (o >= 5 && o <= 7) m_din = 8'(m_snap >> (8 * (o - 4)));
        else m_din = 8'h00;
      end else if (o == 0 && mem_dout != 8'h00) begin
        if (txs < D || txp) txpush = 1'b1;
        else m_ovf = 1'b1;
      end else if (o == 4) m_pd = 1'b1;
    end
    if (txp) void'(m_tx.pop_front());
    if (txpush) m_tx.push_back(mem_dout);
    if (rxp) m_rx.push_back(rx_data);
    m_cnt = m_cnt + 1;
  endtask

  task automatic check_all();
    chk("mem_din", mem_din, m_din);
    chk("tx_valid", tx_valid, m_tx.size() > 0);
    chk("tx_data", tx_data, m_tx.size() > 0 ? m_tx[0] : 8'h00);
    chk("rx_ready", rx_ready, m_rx.size() < D);
    chk("io_buffer_full", io_buffer_full, m_tx.size() == D);
    chk("prog_done", prog_done, m_pd);
    chk("tx_overflow", tx_overflow, m_ovf);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #1;
    chk("rst mem_din", mem_din, 8'h00);
    chk("rst io_buffer_full", io_buffer_full, 1'b0);
    chk("rst rx_ready", rx_ready, 1'b1);
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst prog_done", prog_done, 1'b0);
    chk("rst tx_overflow", tx_overflow, 1'b0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    m_rx.delete();
    m_tx.delete();
    m_cnt = 0;
    m_snap = 0;
    m_din = 8'h00;
    m_pd = 1'b0;
    m_ovf = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tx_ready = 1'b0;
    op(32'h3_0002, 8'h00, 1'b0);
    do_reset();

    tv.push_back('{32'h0_0010, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h00});
    tv.push_back('{32'h0_0010, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5});
    tv.push_back('{32'h1_FFFF, 8'h5A, 1'b1, 1'b0, 8'h00, 8'hA5});
    tv.push_back('{32'h0_0000, 8'hC3, 1'b1, 1'b0, 8'h00, 8'hA5});
    tv.push_back('{32'h1_FFFF, 8'h00, 1'b0, 1'b0, 8'h00, 8'h5A});
    tv.push_back('{32'h0_0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'hC3});
    tv.push_back('{32'h4_0010, 8'h00, 1'b0, 1'b0, 8'h00, 8'hA5});
    tv.push_back('{32'h0_0010, 8'h00, 1'b0, 1'b1, 8'h41, 8'hA5});
    tv.push_back('{32'h0_0010, 8'h00, 1'b0, 1'b1, 8'h42, 8'hA5});
    tv.push_back('{32'h3_0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h41});
    tv.push_back('{32'h3_0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h42});
    tv.push_back('{32'h3_0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00});
    tv.push_back('{32'h3_0000, 8'h00, 1'b0, 1'b1, 8'h77, 8'h00});
    tv.push_back('{32'h3_0000, 8'h00, 1'b0, 1'b0, 8'h00, 8'h77});
    tv.push_back('{32'h3_0004, 8'h01, 1'b1, 1'b0, 8'h00, 8'h77});
    tv.push_back('{32'h3_0003, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00});
    foreach (tv[i]) begin
      op(tv[i].addr, tv[i].dout, tv[i].wr);
      rx_valid = tv[i].rxv;
      rx_data = tv[i].rxd;
      step();
      chk($sformatf("vec%0d mem_din", i), mem_din, tv[i].exp);
      chk($sformatf("vec%0d rx_ready", i), rx_ready, 1'b1);
    end
    rx_valid = 1'b0;
    chk("prog_done sticky", prog_done, 1'b1);

    op(32'h3_0000, 8'h00, 1'b1);
    step();
    chk("zero write no push", tx_valid, 1'b0);
    for (int i = 1; i <= D; i++) begin
      op(32'h3_0000, 8'(i), 1'b1);
      step();
      if (i == D - 1) chk("not full at 15", io_buffer_full, 1'b0);
    end
    chk("full at 16", io_buffer_full, 1'b1);
    chk("head is 1", tx_data, 8'h01);
    tx_ready = 1'b1;
    op(32'h3_0000, 8'h99, 1'b1);
    step();
    chk("push+pop full keeps full", io_buffer_full, 1'b1);
    chk("push+pop full no overflow", tx_overflow, 1'b0);
    tx_ready = 1'b0;
    op(32'h3_0000, 8'h11, 1'b1);
    step();
    chk("overflow set", tx_overflow, 1'b1);
    tx_ready = 1'b1;
    op(32'h3_0002, 8'h00, 1'b0);
    for (int i = 2; i <= D + 1; i++) begin
      chk($sformatf("drain %0d", i), tx_data, i == D + 1 ? 8'h99 : 8'(i));
      step();
    end
    chk("drained", tx_valid, 1'b0);
    tx_ready = 1'b0;

    op(32'h0_0010, 8'h00, 1'b0);
    rx_valid = 1'b1;
    rx_data = 8'h55;
    step();
    rx_valid = 1'b0;
    rdy_in = 1'b0;
    op(32'h0_0010, 8'hEE, 1'b1);
    step();
    step();
    op(32'h3_0000, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("stall mem_din held", mem_din, 8'hA5);
    rdy_in = 1'b1;
    op(32'h0_0010, 8'h00, 1'b0);
    step();
    chk("stall ram unchanged", mem_din, 8'hA5);
    op(32'h3_0000, 8'h00, 1'b0);
    step();
    chk("stall rx unpopped", mem_din, 8'h55);
    op(32'h3_0004, 8'h00, 1'b0);
    step();

    do_reset();
    op(32'h3_0002, 8'h00, 1'b0);
    while (m_cnt != 32'd255) step();
    op(32'h3_0004, 8'h00, 1'b0);
    step();
    chk("snap byte0", mem_din, 8'hFF);
    op(32'h3_0005, 8'h00, 1'b0);
    step();
    chk("snap byte1 no tear", mem_din, 8'h00);
    op(32'h3_0006, 8'h00, 1'b0);
    step();
    chk("snap byte2", mem_din, 8'h00);

    for (int i = 0; i < 16; i++) begin
      op(32'(i), 8'($urandom), 1'b1);
      step();
    end
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        op(32'h3_0002, 8'h00, 1'b0);
        do_reset();
      end
      rdy_in = ($urandom % 8) != 0;
      rx_valid = $urandom % 2;
      rx_data = 8'($urandom);
      tx_ready = ($urandom % 3) == 0;
      if ($urandom % 2)
        op(($urandom & 32'hFFFC_0000) | 32'($urandom % 16), 8'($urandom), 1'($urandom));
      else
        op(($urandom & 32'hFFFC_0000) | 32'h3_0000 | 32'($urandom % 8),
           ($urandom % 4) == 0 ? 8'h00 : 8'($urandom), ($urandom % 3) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
